instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/instruction_fetch_unit.sv | 145 ++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Purpose: sequential instruction fetcher with a single outstanding memory read and a DEPTH-entry prefetch FIFO.
// Latency: mem_req/mem_addr are registered one edge after the issue decision; instr_valid rises the cycle after mem_ack.
// Backpressure: no read is issued while the FIFO is full; instr_ready pops the head; redirect flushes and restarts fetch.
//
// Ports:
//   clk, rst_n                 - clock (rising edge) and asynchronous active-low reset
//   mem_req, mem_addr          - registered read request, held stable until mem_ack
//   mem_ack, mem_rdata         - read completion, data valid in the ack cycle
//   instr_valid, instr,
//   instr_pc, instr_ready      - FIFO head to the decoder, popped on valid && ready
//   redirect, redirect_pc      - taken jump/branch pulse and its target (low two bits ignored)
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t           state;
    logic [31:0]      fetch_pc;
    logic [31:0]      fifo_instr [DEPTH];
    logic [31:0]      fifo_pc    [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    logic [31:0]      redirect_tgt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Redirect wins over everything: an ack or pop in the redirect cycle is dropped.
    assign push         = (state == REQ) && mem_ack && !redirect;
    assign pop          = instr_valid && instr_ready && !redirect;
    assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

    assign instr_valid = (count != '0);
    // Head is masked when empty so stale entries never reach the decoder.
    assign instr       = instr_valid ? fifo_instr[rd_ptr] : '0;
    assign instr_pc    = instr_valid ? fifo_pc[rd_ptr]    : '0;

    // Fetch FSM; mem_req and mem_addr are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            mem_req  <= 1'b0;
            mem_addr <= RESET_PC;
        end else begin
            if (redirect) begin
                fetch_pc <= redirect_tgt;
            end
            case (state)
                IDLE: begin
                    // count cannot grow while a request is pending, so checking
                    // here guarantees the eventual push has room.
                    if (!redirect && (count < FULL_CNT)) begin
                        state    <= REQ;
                        mem_req  <= 1'b1;
                        mem_addr <= fetch_pc;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        if (!redirect) begin
                            fetch_pc <= fetch_pc + 32'd4;
                        end
                    end else if (redirect) begin
                        // Request cannot be withdrawn; its data is dropped on ack.
                        state <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    // FIFO occupancy and pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (!push && pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // FIFO storage; contents are only visible through the masked head.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr] <= mem_rdata;
            fifo_pc[wr_ptr]    <= mem_addr;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;
    localparam logic [31:0] KEY = 32'hA5A5_5A5A;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    // Second instance exercising the address wrap from the top of memory.
    logic        mem_req2;
    logic [31:0] mem_addr2;
    logic        mem_ack2;
    logic [31:0] mem_rdata2;
    logic        instr_valid2;
    logic [31:0] instr2;
    logic [31:0] instr_pc2;
    logic        instr_ready2;
    logic        redirect2;
    logic [31:0] redirect_pc2;

    int ack_delay = 0;
    int wait_cnt;
    int checks;
    int errors;

    logic [31:0] acc_pc[$];
    logic [31:0] acc_in[$];

    always #5 clk = ~clk;

    // Memory model: ack once the request has been pending ack_delay cycles.
    assign mem_ack   = mem_req && (wait_cnt >= ack_delay);
    assign mem_rdata = mem_ack ? (mem_addr ^ KEY) : 32'hDEAD_BEEF;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 wait_cnt <= 0;
        else if (mem_req && mem_ack) wait_cnt <= 0;
        else if (mem_req)           wait_cnt <= wait_cnt + 1;
    end

    assign mem_ack2     = mem_req2;
    assign mem_rdata2   = mem_addr2 ^ KEY;
    assign instr_ready2 = 1'b1;
    assign redirect2    = 1'b0;
    assign redirect_pc2 = 32'h0;

    // Log of instructions actually accepted by the decoder.
    always @(negedge clk) begin
        if (rst_n && instr_valid && instr_ready && !redirect) begin
            acc_pc.push_back(instr_pc);
            acc_in.push_back(instr);
        end
    end

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req2), .mem_addr(mem_addr2), .mem_ack(mem_ack2), .mem_rdata(mem_rdata2),
        .instr_valid(instr_valid2), .instr(instr2), .instr_pc(instr_pc2), .instr_ready(instr_ready2),
        .redirect(redirect2), .redirect_pc(redirect_pc2)
    );

    // Reset both instances; returns on a falling edge with rst_n just released.
    task automatic do_reset(input int dly, input logic rdy);
        @(posedge clk); #1;
        rst_n = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        instr_ready = rdy; ack_delay = dly;
        repeat (2) @(posedge clk);
        @(negedge clk);
        acc_pc.delete(); acc_in.delete();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; instr_ready = 1'b1; ack_delay = 0; redirect = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h want 00000000", mem_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid got %b want 0", instr_valid); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 00000000", instr); end
        checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_instr_pc got %h want 00000000", instr_pc); end
        checks++; if (mem_addr2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL reset_mem_addr2 got %h want fffffffc", mem_addr2); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL first_edge_req got %b want 1", mem_req); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL first_edge_addr got %h want 00000000", mem_addr); end
    endtask

    task automatic test_stream;
        int seen;
        int cyc;
        int at_cyc[4];
        logic [31:0] pcs[4];
        logic [31:0] ins[4];
        do_reset(0, 1'b1);
        seen = 0; cyc = 0;
        while (seen < 4 && cyc < 40) begin
            @(negedge clk); cyc++;
            if (instr_valid && instr_ready) begin
                pcs[seen] = instr_pc; ins[seen] = instr; at_cyc[seen] = cyc; seen++;
            end
        end
        checks++; if (seen != 4) begin errors++; $display("FAIL stream_count got %0d want 4", seen); end
        for (int k = 0; k < seen; k++) begin
            checks++; if (pcs[k] !== 32'(4 * k)) begin errors++; $display("FAIL stream_pc%0d got %h want %h", k, pcs[k], 32'(4 * k)); end
            checks++; if (ins[k] !== (32'(4 * k) ^ KEY)) begin errors++; $display("FAIL stream_instr%0d got %h want %h", k, ins[k], 32'(4 * k) ^ KEY); end
            checks++; if (at_cyc[k] != 2 * (k + 1)) begin errors++; $display("FAIL stream_cycle%0d got %0d want %0d", k, at_cyc[k], 2 * (k + 1)); end
        end
    endtask

    task automatic test_backpressure;
        do_reset(0, 1'b0);
        repeat (6) @(negedge clk);
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b want 1", instr_valid); end
        checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL bp_head_pc got %h want 00000000", instr_pc); end
        checks++; if (instr !== (32'h0 ^ KEY)) begin errors++; $display("FAIL bp_head_instr got %h want %h", instr, KEY); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL bp_full_no_req got %b want 0", mem_req); end
        @(posedge clk); #1; instr_ready = 1'b1;
        @(posedge clk); #1; instr_ready = 1'b0;
        @(negedge clk);
        checks++; if (instr_pc !== 32'h4) begin errors++; $display("FAIL bp_pop_pc got %h want 00000004", instr_pc); end
        @(negedge clk);
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL bp_refill_req got %b want 1", mem_req); end
        checks++; if (mem_addr !== 32'h8) begin errors++; $display("FAIL bp_refill_addr got %h want 00000008", mem_addr); end
    endtask

    task automatic test_redirect_full;
        do_reset(0, 1'b0);
        repeat (6) @(negedge clk);
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL rf_pre_valid got %b want 1", instr_valid); end
        @(posedge clk); #1; redirect = 1'b1; redirect_pc = 32'h0000_0103;
        @(posedge clk); #1; redirect = 1'b0;
        @(negedge clk);
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rf_flush_valid got %b want 0", instr_valid); end
        checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL rf_flush_pc got %h want 00000000", instr_pc); end
        @(negedge clk);
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rf_req got %b want 1", mem_req); end
        checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL rf_addr got %h want 00000100", mem_addr); end
        @(negedge clk);
        checks++; if (instr_pc !== 32'h100) begin errors++; $display("FAIL rf_new_pc got %h want 00000100", instr_pc); end
        checks++; if (instr !== (32'h100 ^ KEY)) begin errors++; $display("FAIL rf_new_instr got %h want %h", instr, 32'h100 ^ KEY); end
    endtask

    task automatic test_redirect_discard;
        int cyc;
        do_reset(3, 1'b1);
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!(mem_req && mem_addr == 32'h8) && cyc < 60);
        checks++; if (cyc >= 60) begin errors++; $display("FAIL rd_wait_req8 got timeout want request at 00000008"); end
        @(posedge clk); #1; redirect = 1'b1; redirect_pc = 32'h0000_0200;
        @(posedge clk); #1; redirect = 1'b0;
        @(negedge clk);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h8) begin errors++; $display("FAIL rd_req_held got req=%b addr=%h want req=1 addr=00000008", mem_req, mem_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rd_flushed got %b want 0", instr_valid); end
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!(mem_req && mem_addr != 32'h8) && cyc < 30);
        checks++; if (mem_addr !== 32'h200) begin errors++; $display("FAIL rd_next_addr got %h want 00000200", mem_addr); end
        cyc = 0;
        while (acc_pc.size() < 3 && cyc < 30) begin @(negedge clk); cyc++; end
        checks++; if (acc_pc.size() != 3) begin errors++; $display("FAIL rd_accept_count got %0d want 3", acc_pc.size()); end
        else begin
            checks++; if (acc_pc[0] !== 32'h0 || acc_pc[1] !== 32'h4 || acc_pc[2] !== 32'h200)
                begin errors++; $display("FAIL rd_order got %h %h %h want 00000000 00000004 00000200", acc_pc[0], acc_pc[1], acc_pc[2]); end
        end
    endtask

    task automatic test_redirect_ack;
        int cyc;
        do_reset(2, 1'b0);
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!(mem_req && mem_addr == 32'h4 && wait_cnt == 1) && cyc < 60);
        checks++; if (cyc >= 60) begin errors++; $display("FAIL ra_wait_req4 got timeout want request at 00000004"); end
        @(posedge clk); #1; redirect = 1'b1; redirect_pc = 32'h0000_0302; instr_ready = 1'b1;
        @(negedge clk);
        checks++; if (mem_ack !== 1'b1 || instr_valid !== 1'b1) begin errors++; $display("FAIL ra_setup got ack=%b valid=%b want 1 1", mem_ack, instr_valid); end
        @(posedge clk); #1; redirect = 1'b0; instr_ready = 1'b0;
        @(negedge clk);
        checks++; if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0)
            begin errors++; $display("FAIL ra_no_stale got valid=%b instr=%h pc=%h want 0 00000000 00000000", instr_valid, instr, instr_pc); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL ra_idle_req got %b want 0", mem_req); end
        @(negedge clk);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h300) begin errors++; $display("FAIL ra_resume got req=%b addr=%h want 1 00000300", mem_req, mem_addr); end
        @(posedge clk); #1; instr_ready = 1'b1;
        cyc = 0;
        while (acc_pc.size() < 1 && cyc < 30) begin @(negedge clk); cyc++; end
        checks++; if (acc_pc.size() < 1) begin errors++; $display("FAIL ra_accept got none want 00000300"); end
        else begin
            checks++; if (acc_pc[0] !== 32'h300 || acc_in[0] !== (32'h300 ^ KEY))
                begin errors++; $display("FAIL ra_first got pc=%h instr=%h want 00000300 %h", acc_pc[0], acc_in[0], 32'h300 ^ KEY); end
        end
    endtask

    task automatic test_reset_mid_req;
        int cyc;
        do_reset(5, 1'b1);
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!mem_req && cyc < 20);
        #2; rst_n = 1'b0; #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL mid_rst_req got %b want 0", mem_req); end
        checks++; if (mem_addr !== 32'h0 || instr_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_state got addr=%h valid=%b want 00000000 0", mem_addr, instr_valid); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin errors++; $display("FAIL mid_rst_reissue got req=%b addr=%h want 1 00000000", mem_req, mem_addr); end
    endtask

    task automatic test_wrap;
        logic [31:0] addrs[2];
        int n;
        do_reset(0, 1'b1);
        n = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (mem_req2 && n < 2) begin addrs[n] = mem_addr2; n++; end
        end
        checks++; if (n != 2) begin errors++; $display("FAIL wrap_req_count got %0d want 2", n); end
        else begin
            checks++; if (addrs[0] !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_first got %h want fffffffc", addrs[0]); end
            checks++; if (addrs[1] !== 32'h0) begin errors++; $display("FAIL wrap_second got %h want 00000000", addrs[1]); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset;
        test_stream;
        test_backpressure;
        test_redirect_full;
        test_redirect_discard;
        test_redirect_ack;
        test_reset_mid_req;
        test_wrap;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
